dmem_write_monitor: RTL and testbench

DMEM_WRITE_MONITOR -- requirements
Module: dmem_write_monitor

---
 rtl/dmem_write_monitor.sv | 141 ++++++++++++++
 tb/tb_dmem_write_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_monitor.sv
// dmem_write_monitor: watches processor data-memory stores to one address,
// queues every captured store word in a small FIFO for a downstream consumer,
// and latches a pass/fail verdict from the first captured word.
module dmem_write_monitor #(
    parameter logic [31:0] WATCH_ADDR  = 32'd200,
    parameter logic [31:0] EXPECT_DATA = 32'h3fe00000,
    parameter int          DEPTH       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        done,
    output logic        pass,
    output logic        overflow,
    output logic [7:0]  wr_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       wr_count_q, wr_count_d;
    state_t           state_q;
    logic             done_q, pass_q;

    logic capture, full, empty, pop, push;

    // A pop needs a word already visible at the head, so a word pushed into an
    // empty FIFO is never popped in the same cycle. When full, a pop frees the
    // slot the incoming word takes, so the push still goes through.
    assign capture = MemWrite && (DataAdr == WATCH_ADDR);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = !empty && out_ready;
    assign push    = capture && (!full || pop);

    // Next-state for FIFO pointers, occupancy and the capture statistics.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_count_d = wr_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (capture && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (capture && (wr_count_q != 8'hff)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    // Control registers; reset discards all queued words and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr_count_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage array; contents are only observable through the occupancy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= WriteData;
        end
    end

    // Verdict FSM: the first captured word decides, and the verdict then holds until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        done_q <= 1'b1;
                        if (WriteData == EXPECT_DATA) begin
                            state_q <= ST_PASS;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FAIL;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                ST_PASS: state_q <= ST_PASS;
                ST_FAIL: state_q <= ST_FAIL;
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    // The head word is masked while empty so out_data reads zero in reset and when idle.
    assign out_valid = !empty;
    assign out_data  = empty ? 32'd0 : mem_q[rd_ptr_q];
    assign done      = done_q;
    assign pass      = pass_q;
    assign overflow  = overflow_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_dmem_write_monitor.sv
// Testbench for dmem_write_monitor: directed scenarios plus randomized traffic,
// checked against a queue-based reference model by a negedge scoreboard monitor.
module tb_dmem_write_monitor;

    localparam logic [31:0] WADDR = 32'd200;
    localparam logic [31:0] EXPV  = 32'h3fe00000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        done;
    logic        pass;
    logic        overflow;
    logic [7:0]  wr_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    int          m_wr_count = 0;
    bit          m_done = 1'b0;
    bit          m_pass = 1'b0;
    bit          m_ovf  = 1'b0;

    dmem_write_monitor #(
        .WATCH_ADDR (WADDR),
        .EXPECT_DATA(EXPV),
        .DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .done     (done),
        .pass     (pass),
        .overflow (overflow),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; the expected word enters the model queue at the edge it is stored.
    task automatic cycle(input bit we, input logic [31:0] adr, input logic [31:0] dat, input bit rdy);
        bit cap;
        bit will_pop;
        bit acc;
        #1;
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = dat;
        out_ready = rdy;
        cap      = we && (adr == WADDR);
        will_pop = (exp_q.size() > 0) && rdy;
        acc      = cap && ((exp_q.size() < DEPTH) || will_pop);
        @(posedge clk);
        if (acc) exp_q.push_back(dat);
        if (cap) begin
            if (m_wr_count < 255) m_wr_count++;
            if (!acc) m_ovf = 1'b1;
            if (!m_done) begin
                m_done = 1'b1;
                m_pass = (dat == EXPV);
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, WADDR, 32'd0, rdy);
    endtask

    // Reset pulse placed between clock edges; outputs must clear with no edge.
    task automatic do_reset();
        #1;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        m_wr_count = 0;
        m_done = 1'b0;
        m_pass = 1'b0;
        m_ovf  = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_wr_count", wr_count, 8'd0);
        #1;
        reset = 1'b1;
    endtask

    // Scoreboard monitor: compares every visible output against the model each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("out_valid", out_valid, exp_q.size() > 0);
                if (exp_q.size() > 0) begin
                    chk("out_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
                chk("done", done, m_done);
                chk("pass", pass, m_pass);
                chk("overflow", overflow, m_ovf);
                chk("wr_count", wr_count, m_wr_count);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          we;
        bit          rdy;
        logic [31:0] adr;
        logic [31:0] dat;
        @(posedge clk);
        do_reset();

        // Pass path
        cycle(1'b1, WADDR, EXPV, 1'b1);
        idle(2, 1'b0);
        chk("pass_path_done", done, 1'b1);
        chk("pass_path_pass", pass, 1'b1);

        // Fail path, second matching write must not change the verdict
        do_reset();
        cycle(1'b1, WADDR, 32'h3fc00000, 1'b0);
        cycle(1'b1, WADDR, EXPV, 1'b0);
        idle(1, 1'b0);
        chk("fail_path_pass", pass, 1'b0);
        chk("fail_path_count", wr_count, 8'd2);
        idle(3, 1'b1);

        // Address filter
        do_reset();
        cycle(1'b1, 32'd196, EXPV, 1'b1);
        cycle(1'b1, 32'd204, EXPV, 1'b1);
        cycle(1'b0, WADDR, EXPV, 1'b1);
        idle(1, 1'b1);
        chk("filter_done", done, 1'b0);

        // Overflow, then drain in order
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, WADDR, 32'h1000 + i, 1'b0);
        idle(1, 1'b0);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", wr_count, 8'd5);
        idle(6, 1'b1);

        // Full with a simultaneous pop, then a write with no pop must drop
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, WADDR, 32'h2000 + i, 1'b0);
        cycle(1'b1, WADDR, 32'h2004, 1'b1);
        idle(1, 1'b0);
        chk("full_pop_ovf", overflow, 1'b0);
        cycle(1'b1, WADDR, 32'h2005, 1'b0);
        idle(6, 1'b1);

        // Reset mid-stream with 3 words queued and a verdict reached
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, WADDR, 32'h3000 + i, 1'b0);
        idle(1, 1'b0);
        do_reset();
        cycle(1'b1, WADDR, EXPV, 1'b0);
        idle(1, 1'b1);
        chk("post_reset_pass", pass, 1'b1);

        // Saturation of wr_count
        do_reset();
        for (int i = 0; i < 270; i++) cycle(1'b1, WADDR, $urandom, 1'b1);
        idle(2, 1'b1);
        chk("sat_count", wr_count, 8'd255);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            we = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0, 1:    adr = WADDR;
                2:       adr = $urandom_range(0, 1) ? 32'd196 : 32'd204;
                default: adr = $urandom;
            endcase
            dat = $urandom_range(0, 1) ? EXPV : $urandom;
            rdy = ($urandom_range(0, 2) != 0);
            cycle(we, adr, dat, rdy);
        end
        idle(8, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
